// File: rtl/fwft_small_fifo_if.sv
// fwft_small_fifo_if: write/read handshake and status flags of the FWFT FIFO.
interface fwft_small_fifo_if #(parameter int WIDTH = 72);
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             nearly_full;
  logic             prog_full;
  logic             empty;
  modport master (output din, wr_en, rd_en, input dout, full, nearly_full, prog_full, empty);
  modport slave  (input din, wr_en, rd_en, output dout, full, nearly_full, prog_full, empty);
endinterface

// File: rtl/fwft_small_fifo.sv
// fwft_small_fifo: first-word-fall-through FIFO, head word on dout with no read latency.
// Define FIFO_ERR_FLAGS_EN to add sticky err_overflow/err_underflow outputs.
module fwft_small_fifo #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = (1 << MAX_DEPTH_BITS) - 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              err_overflow,
  output logic              err_underflow,
`endif
  fwft_small_fifo_if.slave  fifo
);
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_NF   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_PF   = CW'(PROG_FULL_THRESHOLD);
  localparam logic [MAX_DEPTH_BITS-1:0] P_ONE = MAX_DEPTH_BITS'(1);
  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      clr_q;
  logic                      wr_ok, rd_ok;
  always_comb begin
    wr_ok    = fifo.wr_en && !fifo.full;
    rd_ok    = fifo.rd_en && !fifo.empty;
    wr_ptr_d = wr_ok ? wr_ptr_q + P_ONE : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + P_ONE : rd_ptr_q;
    cnt_d    = (wr_ok && !rd_ok) ? cnt_q + C_ONE :
               (rd_ok && !wr_ok) ? cnt_q - C_ONE : cnt_q;
  end
  // clr_q forces dout to zero after reset until the first word lands, since memory is not cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      clr_q    <= 1'b1;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr_q] <= fifo.din;
        clr_q         <= 1'b0;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  assign fifo.dout        = clr_q ? '0 : mem[rd_ptr_q];
  assign fifo.full        = cnt_q == C_FULL;
  assign fifo.nearly_full = cnt_q >= C_NF;
  assign fifo.prog_full   = cnt_q >= C_PF;
  assign fifo.empty       = cnt_q == '0;
`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= err_overflow  | (fifo.wr_en & fifo.full);
      err_underflow <= err_underflow | (fifo.rd_en & fifo.empty);
    end
  end
`endif
endmodule

// File: tb/tb_fwft_small_fifo.sv
// tb_fwft_small_fifo: directed corner cases plus random traffic against a queue model.
module tb_fwft_small_fifo;
  localparam int W = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mq [$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  fwft_small_fifo_if #(.WIDTH(W)) bus ();
`ifdef FIFO_ERR_FLAGS_EN
  logic err_overflow, err_underflow;
`endif
  fwft_small_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(2), .PROG_FULL_THRESHOLD(3)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef FIFO_ERR_FLAGS_EN
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
`endif
    .fifo          (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic verify();
    int n = mq.size();
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("full", 32'(bus.full), 32'(n == D));
    chk("nearly_full", 32'(bus.nearly_full), 32'(n >= D - 1));
    chk("prog_full", 32'(bus.prog_full), 32'(n >= 3));
    if (n > 0) chk("dout", 32'(bus.dout), 32'(mq[0]));
`ifdef FIFO_ERR_FLAGS_EN
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_underflow", 32'(err_underflow), 32'(m_unf));
`endif
  endtask
  task automatic step(input logic w, input logic r, input logic [W-1:0] d, input logic rs = 1'b0);
    bit was_full, was_empty;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.din   = d;
    reset     = rs;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_full  = mq.size() == D;
      was_empty = mq.size() == 0;
      m_ovf |= w && was_full;
      m_unf |= r && was_empty;
      if (r && !was_empty) void'(mq.pop_front());
      if (w && !was_full) mq.push_back(d);
    end
    #1;
    verify();
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    step(0, 0, 8'h00, 1);
    step(1, 1, 8'hEE, 1);
    chk("rst_dout", 32'(bus.dout), 32'h0);
    // 1: single word latency and pop
    step(1, 0, 8'hA5);
    chk("t1_dout", 32'(bus.dout), 32'hA5);
    step(0, 1, 8'h00);
    chk("t1_empty", 32'(bus.empty), 32'h1);
    // 2: fill, overflow drop, drain in order
    for (int i = 1; i <= 5; i++) step(1, 0, W'(i));
    chk("t2_full", 32'(bus.full), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_pop", 32'(bus.dout), 32'(i));
      step(0, 1, 8'h00);
    end
    chk("t2_empty", 32'(bus.empty), 32'h1);
    // 3: read+write while full drops the write
    for (int i = 1; i <= 4; i++) step(1, 0, W'(i));
    step(1, 1, 8'h09);
    chk("t3_dout", 32'(bus.dout), 32'h02);
    chk("t3_full", 32'(bus.full), 32'h0);
    repeat (3) step(0, 1, 8'h00);
    // 4: read+write while empty keeps the write
    step(1, 1, 8'h33);
    chk("t4_dout", 32'(bus.dout), 32'h33);
    step(0, 1, 8'h00);
    // 5: streaming with pointer wrap
    step(1, 0, 8'h00);
    for (int i = 1; i < 10; i++) begin
      chk("t5_order", 32'(bus.dout), 32'(i - 1));
      step(1, 1, W'(i));
    end
    chk("t5_last", 32'(bus.dout), 32'h9);
    step(0, 1, 8'h00);
    // 6: reset with words stored and a write pending
    repeat (3) step(1, 0, 8'h5A);
    step(1, 0, 8'h77, 1);
    chk("t6_empty", 32'(bus.empty), 32'h1);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    step(1, 1, 8'h44);
    // random traffic with varying fill bias and rare resets
    for (int i = 0; i < 600; i++) begin
      int pw = (i / 100) % 2 ? 30 : 70;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 50, W'($urandom),
           $urandom_range(0, 199) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
